// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for common-anode seven-segment displays.
// Every output is a register computed from the next-state counter, digit
// index and snapshot, so the pins always agree with the current slot phase.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | scan stopped (enable low or just out of reset), all dark
// ST_SCAN | slots cycling through digits, counter running
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        digit_index,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(CLK_DIV);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic                    load_snap;
  logic                    frame_nx;

  logic [4*NUM_DIGITS-1:0] snap_data, snap_data_nx;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nx;
  logic [NUM_DIGITS-1:0]   snap_bm, snap_bm_nx;
  logic                    snap_lz, snap_lz_nx;

  logic [NUM_DIGITS-1:0]   hi_zero;
  logic [3:0]              nibble;
  logic                    window;
  logic                    lz_dark;
  logic [NUM_DIGITS-1:0]   anode_nx;
  logic [6:0]              segment_nx;
  logic                    dp_nx;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Next state, slot counter, digit index, snapshot load and frame pulse.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    load_snap = 1'b0;
    frame_nx  = 1'b0;
    if (!enable) begin
      state_nx  = ST_IDLE;
      cnt_nx    = '0;
      idx_nx    = '0;
      load_snap = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // First enabled edge starts a fresh frame at digit 0.
          state_nx  = ST_SCAN;
          cnt_nx    = '0;
          idx_nx    = '0;
          load_snap = 1'b1;
          frame_nx  = 1'b1;
        end
        default: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt_nx = '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              idx_nx    = '0;
              load_snap = 1'b1;
              frame_nx  = 1'b1;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Snapshot as it will be after this edge; outputs decode from it.
  always_comb begin
    snap_data_nx = load_snap ? digit_data  : snap_data;
    snap_dp_nx   = load_snap ? dp_in       : snap_dp;
    snap_bm_nx   = load_snap ? blank_mask  : snap_bm;
    snap_lz_nx   = load_snap ? lz_suppress : snap_lz;
  end

  // hi_zero[i] is set when nibbles i..NUM_DIGITS-1 of the snapshot are zero.
  always_comb begin
    hi_zero = '0;
    hi_zero[NUM_DIGITS-1] = (snap_data_nx[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      hi_zero[i] = hi_zero[i+1] & (snap_data_nx[4*i +: 4] == 4'h0);
    end
  end

  // Pin values for the digit and slot phase that become current on this edge.
  always_comb begin
    anode_nx   = '1;
    segment_nx = 7'h7F;
    dp_nx      = 1'b1;
    nibble     = snap_data_nx[4*int'(idx_nx) +: 4];
    window     = (state_nx == ST_SCAN) && (cnt_nx < CNT_W'(CLK_DIV - BLANK_CYCLES));
    lz_dark    = snap_lz_nx && (idx_nx != '0) && hi_zero[idx_nx];
    if (window) begin
      anode_nx[idx_nx] = 1'b0;
      if (!snap_bm_nx[idx_nx]) begin
        dp_nx = ~snap_dp_nx[idx_nx];
        if (!lz_dark) segment_nx = hex_to_seg(nibble);
      end
    end
  end

  // State, counters, snapshot and registered pin drivers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      snap_data   <= '0;
      snap_dp     <= '0;
      snap_bm     <= '0;
      snap_lz     <= 1'b0;
      anode       <= '1;
      segment     <= 7'h7F;
      dp_out      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      snap_data   <= snap_data_nx;
      snap_dp     <= snap_dp_nx;
      snap_bm     <= snap_bm_nx;
      snap_lz     <= snap_lz_nx;
      anode       <= anode_nx;
      segment     <= segment_nx;
      dp_out      <= dp_nx;
      frame_start <= frame_nx;
    end
  end

  assign digit_index = idx;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised time-multiplexed scan driver for common-anode seven-segment displays.
- Generalises the fixed 4-digit anode counter:
  - internal prescaler, so no external slow clock is needed
  - any digit count
  - hex segment decode and per-digit decimal points
  - per-digit blanking and leading-zero suppression
  - anti-ghosting dead time between digits
  - frame-coherent input snapshot
- Sits between the ALU result/formatting logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; must be ≥ 2.
- CLK_DIV, 100000, clocks per digit slot; must be ≥ 4.
- BLANK_CYCLES, 1000, dead-time clocks at the end of each slot, all anodes off; must satisfy 1 ≤ BLANK_CYCLES < CLK_DIV.
- IDX_W, $clog2(NUM_DIGITS), width of digit_index (derived localparam).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  scan enable; low = display dark
- digit_data  input  4*NUM_DIGITS  hex nibbles; nibble i = bits [4i+3:4i]; digit 0 = rightmost
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_mask  input  NUM_DIGITS  1 = force digit dark
- lz_suppress  input  1  leading-zero suppression enable
- anode  output  NUM_DIGITS  active-low anode drive
- segment  output  7  active-low segments {g,f,e,d,c,b,a}
- dp_out  output  1  active-low decimal point
- digit_index  output  IDX_W  digit currently scanned
- frame_start  output  1  one-clock pulse when digit 0's slot begins

Behaviour:
- Reset (async, reset_n low):
  - slot counter = 0, digit_index = 0
  - snapshot registers = 0
  - anode = all 1s, segment = 7'h7F, dp_out = 1, frame_start = 0
- Reset may assert at any cycle mid-scan. On release, with enable high, a fresh frame begins at digit 0 and counter 0.
- All outputs are registers. They update on the same edge as counter/digit_index, so they are always consistent with the current counter value and glitch-free.
- Enable low:
  - counter and digit_index are held at 0
  - outputs are dark (as in reset)
  - snapshot loads digit_data, dp_in, blank_mask and lz_suppress every clock
  - frame_start = 0
- Enable high, slot counter:
  - counter increments every clock over 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and digit_index advances, wrapping from NUM_DIGITS-1 to 0.
- Display window: counter < CLK_DIV-BLANK_CYCLES.
  - anode[digit_index] = 0; all other anodes = 1.
  - Segments and dp are driven for the selected digit.
- Dead time: counter ≥ CLK_DIV-BLANK_CYCLES.
  - anode = all 1s, segment = 7'h7F, dp_out = 1.
- Snapshot:
  - Loads on the edge where digit_index wraps NUM_DIGITS-1 → 0, and while enable is low.
  - Input changes mid-frame never appear until the next frame.
- frame_start = 1 for exactly the first clock of each digit-0 slot.
- This includes the first clock after enable rises and the first clock after reset is released with enable high.
- Decode (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Digit suppression:
  - Digit i is dark (segment = 7'h7F, dp_out = 1) if blank_mask[i] is set.
  - Digit i is also dark if lz_suppress is set, i ≠ 0, and nibbles i..NUM_DIGITS-1 of the snapshot are all zero.
  - Digit 0 is never suppressed by lz_suppress.
- The anode of a suppressed digit still pulses low during its window, keeping scan timing uniform.
- dp_out = ~dp_in[i], except when digit i is blanked by blank_mask.
- A leading-zero-suppressed digit still shows its dp if dp_in[i] is set.

Test Plan:
- Tests 1–4 use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Test 5 changes only NUM_DIGITS.
- Test 1, reset and scan order:
  - Stimulus: digit_data=16'h1234, enable=1, release reset.
  - Anode sequence per slot is 1110, 1101, 1011, 0111 and then repeats.
  - Each slot: anode active for 6 clocks, then 2 clocks of all 1s.
  - Segments are 4→0011001 (slot 0), 3→0110000, 2→0100100, 1→1111001.
  - frame_start pulses every 32 clocks.
- Test 2, snapshot coherency:
  - Stimulus: change digit_data from 16'h1234 to 16'hABCD during digit 1's slot.
  - Digits 2 and 3 still show 2 and 1.
  - The next frame shows D, C, b, A.
- Test 3, leading-zero suppression:
  - Stimulus: digit_data=16'h0005, lz_suppress=1.
  - Digits 3, 2 and 1 have segment=7F; digit 0 has segment=0010010.
  - With digit_data=16'h0000: only digit 0 is lit, showing 1000000.
  - With lz_suppress=0: all four digits show 0.
- Test 4, blank_mask and dp:
  - Stimulus: blank_mask=4'b0100, dp_in=4'b0110, digit_data=16'h8888.
  - Digit 2 is fully dark: segment=7F, dp_out=1.
  - Digit 1 shows 0000000 with dp_out=0.
  - Digits 0 and 3 have dp_out=1.
- Test 5, enable and reset mid-operation:
  - Deassert enable during digit 2's slot: outputs go dark on the next edge, and digit_index and counter read 0.
  - Re-enable: digit_index=0 and frame_start=1 on the first enabled edge.
  - Assert reset_n low mid-slot: outputs go dark immediately, without waiting for a clock edge.
  - Run with NUM_DIGITS=8, CLK_DIV=8, BLANK_CYCLES=2: the anode sequence covers all 8 one-cold patterns and wraps from index 7 to 0.
